mem_arbiter: RTL

- Shares the single byte-wide unified memory port between NUM_REQ requesters, e.g. instruction fetch, load execution and store execution.
- One transaction is outstanding at a time. Arbitration is round-robin.
- A requester may hold the port across a burst with a lock input, limited by a fairness cap.
- Read data and the acknowledge are routed back only to the requester that owns the transaction.

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide memory port between NUM_REQ requesters. Only one
//   transaction is outstanding at a time. Arbitration is round-robin. A
//   requester can hold the port for a locked burst, up to MAX_BURST
//   consecutive grants.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/we/lock       per-requester request, write select, burst lock
//   req_addr, req_wdata     packed per-requester address / write data
//   req_ack, req_rdata      one-hot completion pulse, read data (with ack)
//   grant, busy             owner of the in-flight transaction, in-flight flag
//   mem_req, mem_we         1-cycle request pulse, write qualifier
//   mem_addr, mem_wdata     held from mem_req until mem_valid
//   mem_rdata, mem_valid    memory read data, completion strobe
//
// state | meaning
// IDLE  | no transaction; arbitrate when any req_valid is high
// ISSUE | mem_req pulse; mem_valid here completes at once
// WAIT  | hold address/data until mem_valid
module mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_valid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state, state_nxt;
  logic [NUM_REQ-1:0]     grant_nxt;
  logic                   busy_nxt;
  logic                   mem_we_nxt;
  logic [ADDR_WIDTH-1:0]  mem_addr_nxt;
  logic [DATA_WIDTH-1:0]  mem_wdata_nxt;
  logic [IW-1:0]          last_grant, last_grant_nxt;
  logic [BW-1:0]          burst_cnt, burst_cnt_nxt;
  logic                   lock_pending, lock_pending_nxt;
  logic [IW-1:0]          rr_idx;
  logic                   rr_found;
  logic                   lock_win;
  logic [IW-1:0]          win;
  logic                   done;

  // First requester after last_grant, wrapping; last_grant itself is checked last.
  always_comb begin
    int cand;
    cand     = 0;
    rr_idx   = last_grant;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!rr_found && req_valid[cand]) begin
        rr_idx   = IW'(cand);
        rr_found = 1'b1;
      end
    end
  end

  // lock_pending survives idle cycles so the owner keeps priority until an
  // arbitration finds it not requesting.
  assign lock_win = lock_pending && req_valid[last_grant] && (burst_cnt < BURST_LAST);
  assign done     = ((state == ISSUE) || (state == WAIT)) && mem_valid;

  assign mem_req   = (state == ISSUE);
  assign req_ack   = done ? grant : '0;
  assign req_rdata = mem_rdata;

  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant;
    busy_nxt         = busy;
    mem_we_nxt       = mem_we;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    last_grant_nxt   = last_grant;
    burst_cnt_nxt    = burst_cnt;
    lock_pending_nxt = lock_pending;
    win              = rr_idx;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          if (lock_win) begin
            win           = last_grant;
            burst_cnt_nxt = burst_cnt + BW'(1);
          end else begin
            win           = rr_idx;
            burst_cnt_nxt = '0;
          end
          lock_pending_nxt = 1'b0;
          grant_nxt        = '0;
          grant_nxt[win]   = 1'b1;
          busy_nxt         = 1'b1;
          last_grant_nxt   = win;
          mem_we_nxt       = req_we[win];
          mem_addr_nxt     = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_nxt    = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
          state_nxt        = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        state_nxt = WAIT;
        if (mem_valid) begin
          lock_pending_nxt = req_lock[last_grant];
          grant_nxt        = '0;
          busy_nxt         = 1'b0;
          state_nxt        = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= '0;
      busy         <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      last_grant   <= IW'(NUM_REQ - 1);
      burst_cnt    <= '0;
      lock_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      busy         <= busy_nxt;
      mem_we       <= mem_we_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      last_grant   <= last_grant_nxt;
      burst_cnt    <= burst_cnt_nxt;
      lock_pending <= lock_pending_nxt;
    end
  end

endmodule
